// File: rtl/mb_mem_responder.sv
// Responder for the mb_op / mb_ack / mb_done bridge.
// Services each initiator request on a req/gnt/rvalid memory bus.
// Commits preload words into the initiator's cache while the initiator is idle.
// Every output is registered. mb_done trails the DONE state by one cycle.
// This keeps freshly captured read data stable for a full cycle before the
// completion pulse.
module mb_mem_responder #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mb_op,
  input  logic [31:0] mb_addr,
  input  logic [31:0] mb_data_out,
  output logic        mb_ack,
  output logic        mb_done,
  output logic [31:0] mb_data_in,
  output logic        mb_data_we,
  output logic [31:0] mb_addr_in,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_gnt,
  input  logic        ext_rvalid,
  input  logic [31:0] ext_rdata,
  input  logic        pl_valid,
  input  logic [19:0] pl_addr,
  input  logic [31:0] pl_data,
  output logic        pl_ready,
  output logic        err
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    ISSUE,
    WAIT_RESP,
    DONE,
    PL_SETUP,
    PL_COMMIT
  } state_t;

  state_t           state, state_nxt;
  logic             take_req;
  logic             req_read, req_read_nxt;
  logic [31:0]      req_addr, req_addr_nxt;
  logic [31:0]      req_data, req_data_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timed_out;

  logic             ack_nxt, done_nxt, data_we_nxt, pl_ready_nxt, err_nxt;
  logic [31:0]      data_in_nxt, addr_in_nxt;
  logic             ext_req_nxt, ext_we_nxt;
  logic [31:0]      ext_addr_nxt, ext_wdata_nxt;

  // Next-state decode plus the next value of every registered output
  always_comb begin
    state_nxt    = state;
    take_req     = 1'b0;
    cnt_nxt      = cnt;
    data_in_nxt  = mb_data_in;
    data_we_nxt  = 1'b0;
    addr_in_nxt  = mb_addr_in;
    pl_ready_nxt = 1'b0;
    err_nxt      = err;
    timed_out    = (cnt == CNT_LAST);

    case (state)
      IDLE: begin
        if (mb_op == 4'd1 || mb_op == 4'd4) begin
          take_req  = 1'b1;
          state_nxt = ACK;
        end else if (mb_op == 4'd0 && pl_valid) begin
          addr_in_nxt = {12'b0, pl_addr};
          data_in_nxt = pl_data;
          state_nxt   = PL_SETUP;
        end
      end
      ACK: begin
        cnt_nxt   = '0;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        if (ext_gnt) begin
          if (req_read) begin
            cnt_nxt   = '0;
            state_nxt = WAIT_RESP;
          end else begin
            state_nxt = DONE;
          end
        end else if (timed_out) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
          if (req_read) begin
            data_in_nxt = ERR_DATA;
            data_we_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_RESP: begin
        if (ext_rvalid) begin
          data_in_nxt = ext_rdata;
          data_we_nxt = 1'b1;
          state_nxt   = DONE;
        end else if (timed_out) begin
          data_in_nxt = ERR_DATA;
          data_we_nxt = 1'b1;
          err_nxt     = 1'b1;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      PL_SETUP: begin
        state_nxt = PL_COMMIT;
      end
      PL_COMMIT: begin
        if (mb_op == 4'd0) begin
          pl_ready_nxt = 1'b1;
          state_nxt    = IDLE;
        end else if (mb_op == 4'd1 || mb_op == 4'd4) begin
          take_req  = 1'b1;
          state_nxt = ACK;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    req_read_nxt  = take_req ? (mb_op == 4'd4) : req_read;
    req_addr_nxt  = take_req ? mb_addr : req_addr;
    req_data_nxt  = take_req ? mb_data_out : req_data;

    ack_nxt       = (state_nxt == ACK);
    done_nxt      = (state == DONE) || (state_nxt == PL_COMMIT);
    ext_req_nxt   = (state_nxt == ISSUE);
    ext_we_nxt    = ext_req_nxt && !req_read_nxt;
    ext_addr_nxt  = ext_req_nxt ? req_addr_nxt : 32'h0;
    ext_wdata_nxt = ext_req_nxt ? req_data_nxt : 32'h0;
  end

  // State, latched request, timeout counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_read   <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      cnt        <= '0;
      mb_ack     <= 1'b0;
      mb_done    <= 1'b0;
      mb_data_in <= '0;
      mb_data_we <= 1'b0;
      mb_addr_in <= '0;
      ext_req    <= 1'b0;
      ext_we     <= 1'b0;
      ext_addr   <= '0;
      ext_wdata  <= '0;
      pl_ready   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      req_read   <= req_read_nxt;
      req_addr   <= req_addr_nxt;
      req_data   <= req_data_nxt;
      cnt        <= cnt_nxt;
      mb_ack     <= ack_nxt;
      mb_done    <= done_nxt;
      mb_data_in <= data_in_nxt;
      mb_data_we <= data_we_nxt;
      mb_addr_in <= addr_in_nxt;
      ext_req    <= ext_req_nxt;
      ext_we     <= ext_we_nxt;
      ext_addr   <= ext_addr_nxt;
      ext_wdata  <= ext_wdata_nxt;
      pl_ready   <= pl_ready_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mb_mem_responder.sv
// Directed bench for mb_mem_responder.
// Stimulus and expected outputs are planned per cycle from transaction-level
// descriptions before the run. A compare process checks every output on every
// cycle, and a few literal values pin the plan itself.
// Cycle k inputs are applied just after clock edge k and sampled at edge k+1.
// Outputs registered at edge k are observed in cycle k, on the falling edge.
module tb_mb_mem_responder;

  localparam int          N   = 92;
  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mb_op;
  logic [31:0] mb_addr, mb_data_out;
  logic        mb_ack, mb_done, mb_data_we;
  logic [31:0] mb_data_in, mb_addr_in;
  logic        ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        pl_valid, pl_ready, err;
  logic [19:0] pl_addr;
  logic [31:0] pl_data;

  // per-cycle stimulus table
  logic        st_rst[N], st_gnt[N], st_rvalid[N], st_pl_valid[N];
  logic [3:0]  st_op[N];
  logic [31:0] st_addr[N], st_wdata[N], st_rdata[N], st_pl_data[N];
  logic [19:0] st_pl_addr[N];

  // per-cycle expected outputs
  logic        ex_ack[N], ex_done[N], ex_we[N], ex_req[N], ex_ewe[N];
  logic        ex_plr[N], ex_err[N];
  logic [31:0] ex_din[N], ex_ain[N], ex_eaddr[N], ex_ewdata[N];

  int cyc = 0;
  int num_checks = 0;
  int num_fail = 0;

  mb_mem_responder #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst), .mb_op(mb_op), .mb_addr(mb_addr),
    .mb_data_out(mb_data_out), .mb_ack(mb_ack), .mb_done(mb_done),
    .mb_data_in(mb_data_in), .mb_data_we(mb_data_we),
    .mb_addr_in(mb_addr_in), .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .pl_valid(pl_valid),
    .pl_addr(pl_addr), .pl_data(pl_data), .pl_ready(pl_ready), .err(err)
  );

  // free-running clock, period 10
  always #5 clk = ~clk;

  task automatic clearPlan();
    for (int c = 0; c < N; c++) begin
      st_rst[c] = 1'b0; st_gnt[c] = 1'b0; st_rvalid[c] = 1'b0;
      st_pl_valid[c] = 1'b0; st_op[c] = 4'd0; st_addr[c] = 32'h0;
      st_wdata[c] = 32'h0; st_rdata[c] = 32'hF00D_0000 | 32'(c);
      st_pl_data[c] = 32'h0; st_pl_addr[c] = 20'h0;
      ex_ack[c] = 1'b0; ex_done[c] = 1'b0; ex_we[c] = 1'b0;
      ex_req[c] = 1'b0; ex_ewe[c] = 1'b0; ex_plr[c] = 1'b0;
      ex_err[c] = 1'b0; ex_din[c] = 32'h0; ex_ain[c] = 32'h0;
      ex_eaddr[c] = 32'h0; ex_ewdata[c] = 32'h0;
    end
  endtask

  task automatic setOp(input int from, input int to, input logic [3:0] v);
    for (int c = from; c <= to; c++) st_op[c] = v;
  endtask

  task automatic holdDin(input int from, input logic [31:0] v);
    for (int c = from; c < N; c++) ex_din[c] = v;
  endtask

  task automatic holdAin(input int from, input logic [31:0] v);
    for (int c = from; c < N; c++) ex_ain[c] = v;
  endtask

  task automatic holdErr(input int from, input logic v);
    for (int c = from; c < N; c++) ex_err[c] = v;
  endtask

  // Request raised in cycle a, granted in cycle g: ack one cycle later,
  // bus request from the following cycle until the grant cycle.
  task automatic planRequest(input int a, input int g, input bit is_read,
                             input logic [31:0] addr, input logic [31:0] wd);
    setOp(a, a + 1, is_read ? 4'd4 : 4'd1);
    for (int c = a; c <= g; c++) begin
      st_addr[c] = addr;
      st_wdata[c] = wd;
    end
    st_gnt[g] = 1'b1;
    ex_ack[a + 1] = 1'b1;
    for (int c = a + 2; c <= g; c++) begin
      ex_req[c] = 1'b1;
      ex_ewe[c] = !is_read;
      ex_eaddr[c] = addr;
      ex_ewdata[c] = wd;
    end
  endtask

  // A write completes two cycles after its grant cycle.
  task automatic planWriteDone(input int a, input int g);
    setOp(a + 2, g + 1, 4'd2);
    setOp(g + 2, g + 2, 4'd3);
    ex_done[g + 2] = 1'b1;
  endtask

  // Read data presented in cycle r (or the wait expiring in cycle r) is
  // visible with its strobe in r+1; the done pulse follows one cycle later.
  task automatic planReadDone(input int a, input int r,
                              input logic [31:0] d, input bit timeout);
    setOp(a + 2, r + 1, 4'd5);
    setOp(r + 2, r + 2, 4'd6);
    if (!timeout) begin
      st_rvalid[r] = 1'b1;
      st_rdata[r] = d;
    end
    ex_we[r + 1] = 1'b1;
    holdDin(r + 1, timeout ? ERR : d);
    if (timeout) holdErr(r + 1, 1'b1);
    ex_done[r + 2] = 1'b1;
  endtask

  task automatic setPl(input int from, input int to,
                       input logic [19:0] a, input logic [31:0] d);
    for (int c = from; c <= to; c++) begin
      st_pl_valid[c] = 1'b1;
      st_pl_addr[c] = a;
      st_pl_data[c] = d;
    end
  endtask

  // Preload picked up from cycle p: two cycles of address/data,
  // done in the second, ready afterwards if the initiator stayed idle.
  task automatic planPreload(input int p, input logic [19:0] a,
                             input logic [31:0] d, input bit accepted);
    holdAin(p + 1, {12'h0, a});
    holdDin(p + 1, d);
    ex_done[p + 2] = 1'b1;
    if (accepted) ex_plr[p + 3] = 1'b1;
  endtask

  task automatic planReset(input int k);
    st_rst[k] = 1'b1;
    holdDin(k + 1, 32'h0);
    holdAin(k + 1, 32'h0);
    holdErr(k + 1, 1'b0);
  endtask

  task automatic applyStimulus(input int k);
    rst = st_rst[k];
    mb_op = st_op[k];
    mb_addr = st_addr[k];
    mb_data_out = st_wdata[k];
    ext_gnt = st_gnt[k];
    ext_rvalid = st_rvalid[k];
    ext_rdata = st_rdata[k];
    pl_valid = st_pl_valid[k];
    pl_addr = st_pl_addr[k];
    pl_data = st_pl_data[k];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h",
               name, cyc, actual, expected);
    end
  endtask

  // Compare every output against the plan, plus literal pins at chosen cycles
  always @(negedge clk) begin
    if (cyc >= 1) begin
      checkOutput("mb_ack", 32'(mb_ack), 32'(ex_ack[cyc]));
      checkOutput("mb_done", 32'(mb_done), 32'(ex_done[cyc]));
      checkOutput("mb_data_we", 32'(mb_data_we), 32'(ex_we[cyc]));
      checkOutput("mb_data_in", mb_data_in, ex_din[cyc]);
      checkOutput("mb_addr_in", mb_addr_in, ex_ain[cyc]);
      checkOutput("ext_req", 32'(ext_req), 32'(ex_req[cyc]));
      checkOutput("pl_ready", 32'(pl_ready), 32'(ex_plr[cyc]));
      checkOutput("err", 32'(err), 32'(ex_err[cyc]));
      if (ex_req[cyc]) begin
        checkOutput("ext_we", 32'(ext_we), 32'(ex_ewe[cyc]));
        checkOutput("ext_addr", ext_addr, ex_eaddr[cyc]);
        if (ex_ewe[cyc]) checkOutput("ext_wdata", ext_wdata, ex_ewdata[cyc]);
      end
      case (cyc)
        1: begin
          checkOutput("lit_reset_ack", 32'(mb_ack), 32'd0);
          checkOutput("lit_reset_done", 32'(mb_done), 32'd0);
          checkOutput("lit_reset_err", 32'(err), 32'd0);
          checkOutput("lit_reset_din", mb_data_in, 32'h0);
        end
        5:  checkOutput("lit_wr_ack", 32'(mb_ack), 32'd1);
        8: begin
          checkOutput("lit_wr_addr", ext_addr, 32'h0010_0040);
          checkOutput("lit_wr_data", ext_wdata, 32'hCAFE_0001);
          checkOutput("lit_wr_we", 32'(ext_we), 32'd1);
        end
        9:  checkOutput("lit_wr_req_drop", 32'(ext_req), 32'd0);
        10: checkOutput("lit_wr_done", 32'(mb_done), 32'd1);
        11: checkOutput("lit_wr_done_single", 32'(mb_done), 32'd0);
        20: begin
          checkOutput("lit_rd_data", mb_data_in, 32'h1234_5678);
          checkOutput("lit_rd_we", 32'(mb_data_we), 32'd1);
        end
        21: checkOutput("lit_rd_done", 32'(mb_done), 32'd1);
        26: begin
          checkOutput("lit_pl_addr", mb_addr_in, 32'h0000_0ABC);
          checkOutput("lit_pl_data", mb_data_in, 32'hA5A5_A5A5);
        end
        27: checkOutput("lit_pl_done", 32'(mb_done), 32'd1);
        28: checkOutput("lit_pl_ready", 32'(pl_ready), 32'd1);
        35: begin
          checkOutput("lit_col_ready", 32'(pl_ready), 32'd0);
          checkOutput("lit_col_ack", 32'(mb_ack), 32'd1);
        end
        39: checkOutput("lit_col_done", 32'(mb_done), 32'd1);
        41: begin
          checkOutput("lit_col_reissue_data", mb_data_in, 32'h5A5A_0123);
          checkOutput("lit_col_reissue_addr", mb_addr_in, 32'h0000_0123);
        end
        67: begin
          checkOutput("lit_tmo_data", mb_data_in, 32'hDEAD_BEEF);
          checkOutput("lit_tmo_err", 32'(err), 32'd1);
        end
        68: checkOutput("lit_tmo_done", 32'(mb_done), 32'd1);
        77: checkOutput("lit_tmo_err_sticky", 32'(err), 32'd1);
        78: begin
          checkOutput("lit_rst_err", 32'(err), 32'd0);
          checkOutput("lit_rst_din", mb_data_in, 32'h0);
        end
        85: checkOutput("lit_post_rst_done", 32'(mb_done), 32'd1);
        default: ;
      endcase
    end
  end

  // Build the plan, then drive one table row per cycle
  initial begin
    clearPlan();
    st_rst[0] = 1'b1;
    st_rst[1] = 1'b1;

    // write, grant two cycles after the bus request rises
    planRequest(4, 8, 1'b0, 32'h0010_0040, 32'hCAFE_0001);
    planWriteDone(4, 8);

    // read, immediate grant, data three cycles later
    planRequest(14, 16, 1'b1, 32'h0020_0000, 32'h0BAD_0001);
    planReadDone(14, 19, 32'h1234_5678, 1'b0);

    // preload accepted
    setPl(25, 27, 20'h00ABC, 32'hA5A5_A5A5);
    planPreload(25, 20'h00ABC, 32'hA5A5_A5A5, 1'b1);

    // preload collides with a read, then is reissued
    setPl(32, 42, 20'h00123, 32'h5A5A_0123);
    planPreload(32, 20'h00123, 32'h5A5A_0123, 1'b0);
    planRequest(34, 36, 1'b1, 32'h0030_0010, 32'h0BAD_0002);
    planReadDone(34, 37, 32'h7777_0004, 1'b0);
    planPreload(40, 20'h00123, 32'h5A5A_0123, 1'b1);

    // read whose data never arrives
    planRequest(48, 50, 1'b1, 32'h0040_0000, 32'h0BAD_0003);
    planReadDone(48, 50 + TMO, 32'h0, 1'b1);

    // reset while waiting for read data, then a normal write
    planRequest(72, 74, 1'b1, 32'h0050_0000, 32'h0BAD_0004);
    setOp(74, 77, 4'd5);
    planReset(77);
    planRequest(81, 83, 1'b0, 32'h0040_0008, 32'h1111_2222);
    planWriteDone(81, 83);

    applyStimulus(0);
    for (int k = 1; k < N; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      applyStimulus(k);
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
    $finish;
  end

endmodule
